// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ERR_W        = 2;
  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_RANGE    = 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_ERR
  } lsu_state_e;

  // Request fields still needed after the handshake (word index lives in mem_address).
  typedef struct packed {
    lsu_size_e       size;
    logic            uns;
    logic [1:0]      offset;
    logic [XLEN-1:0] wdata;
  } lsu_lat_t;

  // The reserved size encoding behaves as a word access.
  function automatic lsu_size_e norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : lsu_size_e'(sz);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response handshake of the load/store unit.
//   master: execute stage (drives req_*, receives req_ready and resp_*)
//   slave : load_store_unit
interface lsu_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic [ERR_W-1:0] resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
//   size, offset  : access size and byte offset within the word
//   uns           : 1 = zero-extend loads, 0 = sign-extend
//   old_word      : word read from memory
//   new_data      : store data (byte in [7:0], halfword in [15:0])
//   load_data_c   : extended load result
//   merge_data_c  : old_word with the addressed lane replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e       size,
  input  logic [1:0]      offset,
  input  logic            uns,
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] new_data,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merge_data_c
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian lanes: byte k at [8k+7:8k], halfword h at [16h+15:16h].
  always_comb begin
    byte_sh      = {offset, 3'b000};
    half_sh      = {offset[1], 4'b0000};
    byte_lane    = old_word[byte_sh +: 8];
    half_lane    = old_word[half_sh +: 16];
    load_data_c  = old_word;
    merge_data_c = new_data;
    case (size)
      SZ_BYTE: begin
        load_data_c  = uns ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merge_data_c = old_word;
        merge_data_c[byte_sh +: 8] = new_data[7:0];
      end
      SZ_HALF: begin
        load_data_c  = uns ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merge_data_c = old_word;
        merge_data_c[half_sh +: 16] = new_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide data memory.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus               : request/response handshake (lsu_if.slave)
//   mem_address       : word index to data memory
//   mem_write_data    : word to write
//   mem_write_enable  : write strobe, one cycle per store
//   mem_read_data     : combinational read data from data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_if.slave            bus,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_enable,
  input  logic [XLEN-1:0] mem_read_data
);

  lsu_state_e       state;
  lsu_state_e       state_nxt;
  lsu_lat_t         req_q;
  logic [ERR_W-1:0] err_q;

  logic             handshake_c;
  lsu_size_e        size_in_c;
  logic [ERR_W-1:0] err_c;
  logic [XLEN-1:0]  load_data_c;
  logic [XLEN-1:0]  merge_data_c;

  assign bus.req_ready = (state == ST_IDLE);
  assign handshake_c   = bus.req_valid && bus.req_ready;

  // Error classification of the incoming request.
  always_comb begin
    size_in_c = norm_size(bus.req_size);
    err_c     = '0;
    err_c[ERR_MISALIGN] = ((size_in_c == SZ_HALF) && bus.req_addr[0]) ||
                          ((size_in_c == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    err_c[ERR_RANGE]    = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH));
  end

  lsu_lane_align u_lane_align (
    .size         (req_q.size),
    .offset       (req_q.offset),
    .uns          (req_q.uns),
    .old_word     (mem_read_data),
    .new_data     (req_q.wdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (handshake_c) begin
          if (|err_c)                    state_nxt = ST_ERR;
          else if (!bus.req_we)          state_nxt = ST_LOAD;
          else if (size_in_c == SZ_WORD) state_nxt = ST_WRITE;
          else                           state_nxt = ST_RMW_RD;
        end
      end
      ST_RMW_RD: state_nxt = ST_WRITE;
      ST_LOAD,
      ST_WRITE,
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered outputs; responses are issued on the
  // transition back to IDLE so a new request can overlap resp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      req_q            <= '0;
      err_q            <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.resp_err     <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      state            <= state_nxt;
      bus.resp_valid   <= 1'b0;
      mem_write_enable <= (state_nxt == ST_WRITE);
      case (state)
        ST_IDLE: begin
          if (handshake_c) begin
            req_q.size   <= size_in_c;
            req_q.uns    <= bus.req_unsigned;
            req_q.offset <= bus.req_addr[1:0];
            req_q.wdata  <= bus.req_wdata;
            err_q        <= err_c;
            mem_address  <= {2'b00, bus.req_addr[31:2]};
            if (state_nxt == ST_WRITE) mem_write_data <= bus.req_wdata;
          end
        end
        ST_LOAD: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= load_data_c;
          bus.resp_err   <= '0;
        end
        ST_RMW_RD: begin
          mem_write_data <= merge_data_c;
        end
        ST_WRITE: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          bus.resp_err   <= '0;
        end
        ST_ERR: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          bus.resp_err   <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  logic [31:0] mem [1024];
  int          we_count;
  int          total;
  int          bad;

  lsu_if bus ();

  load_store_unit #(.DEPTH(1024)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, write on posedge.
  assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'hDEAD_0000;

  always @(posedge clk) begin
    if (mem_write_enable) begin
      we_count = we_count + 1;
      if (mem_address < 32'd1024) mem[mem_address[9:0]] = mem_write_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One request; lat = cycles after the handshake edge until resp_valid
  // (1 = first cycle after handshake), we_at = cycle in which the strobe was seen.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int we_at,
                        output logic [31:0] rdata, output logic [1:0] err);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_req addr=%h got=%b want=1", addr, bus.req_ready);
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat   = 1;
    we_at = 0;
    while (1) begin
      if (mem_write_enable === 1'b1) we_at = lat;
      if (bus.resp_valid === 1'b1 || lat >= 10) break;
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 2'b00) begin
      bad++;
      $display("FAIL reset_resp got v=%b d=%h e=%b want 0/0/0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    total++;
    if (mem_write_enable !== 1'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem got we=%b a=%h d=%h want 0/0/0",
               mem_write_enable, mem_address, mem_write_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", bus.req_ready);
    end
  endtask

  task automatic test_loads();
    int lat, we_at;
    logic [31:0] d;
    logic [1:0] e;
    logic [31:0] exp_d [6];
    logic [31:0] addrs [6];
    logic [1:0]  sizes [6];
    logic        unss  [6];
    @(negedge clk);
    mem[1] = 32'h8899_AABB;
    addrs = '{32'h5, 32'h5, 32'h6, 32'h4, 32'h4, 32'h7};
    sizes = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    unss  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_d = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_AABB,
              32'hFFFF_FFBB, 32'h0000_0088};
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, we_at, d, e);
      total++;
      if (d !== exp_d[i] || e !== 2'b00 || lat !== 2) begin
        bad++;
        $display("FAIL load_%0d got d=%h e=%b lat=%0d want d=%h e=00 lat=2",
                 i, d, e, lat, exp_d[i]);
      end
    end
    // Single-cycle pulse, data held afterwards.
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0000_0088) begin
      bad++;
      $display("FAIL load_hold got v=%b d=%h want v=0 d=00000088",
               bus.resp_valid, bus.resp_rdata);
    end
  endtask

  task automatic test_stores();
    int lat, we_at, w0;
    logic [31:0] d;
    logic [1:0] e;
    @(negedge clk);
    mem[1] = 32'h8899_AABB;
    w0 = we_count;
    do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_1234, lat, we_at, d, e);
    total++;
    if (mem[1] !== 32'h1234_AABB || lat !== 3 || we_at !== 2 || we_count !== w0 + 1 || e !== 2'b00) begin
      bad++;
      $display("FAIL store_half got m=%h lat=%0d we_at=%0d n=%0d e=%b want m=1234aabb lat=3 we_at=2 n=%0d e=00",
               mem[1], lat, we_at, we_count, e, w0 + 1);
    end
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFF_FF77, lat, we_at, d, e);
    total++;
    if (mem[1] !== 32'h1234_77BB || lat !== 3 || we_at !== 2) begin
      bad++;
      $display("FAIL store_byte got m=%h lat=%0d we_at=%0d want m=123477bb lat=3 we_at=2",
               mem[1], lat, we_at);
    end
    w0 = we_count;
    do_req(1'b1, 2'b11, 1'b0, 32'hC, 32'hCAFE_F00D, lat, we_at, d, e);
    total++;
    if (mem[3] !== 32'hCAFE_F00D || lat !== 2 || we_at !== 1 || we_count !== w0 + 1 || d !== 32'h0) begin
      bad++;
      $display("FAIL store_word_rsvd got m=%h lat=%0d we_at=%0d n=%0d d=%h want m=cafef00d lat=2 we_at=1 n=%0d d=0",
               mem[3], lat, we_at, we_count, d, w0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    @(negedge clk);
    w0 = we_count;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr  = 32'h8;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (mem_write_enable !== 1'b1 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_write got we=%b rdy=%b want we=1 rdy=0", mem_write_enable, bus.req_ready);
    end
    bus.req_we    = 1'b0;
    bus.req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_overlap got v=%b rdy=%b want v=1 rdy=1", bus.resp_valid, bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got v=%b rdy=%b want v=0 rdy=0", bus.resp_valid, bus.req_ready);
    end
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEAD_BEEF || mem[2] !== 32'hDEAD_BEEF ||
        we_count !== w0 + 1) begin
      bad++;
      $display("FAIL b2b_load got v=%b d=%h m=%h n=%0d want v=1 d=deadbeef m=deadbeef n=%0d",
               bus.resp_valid, bus.resp_rdata, mem[2], we_count, w0 + 1);
    end
  endtask

  task automatic test_errors();
    int lat, we_at, w0;
    logic [31:0] d;
    logic [1:0] e;
    @(negedge clk);
    mem[1023] = 32'h1122_3344;
    w0 = we_count;
    do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, lat, we_at, d, e);
    total++;
    if (e !== 2'b01 || d !== 32'h0 || lat !== 2 || we_at !== 0) begin
      bad++;
      $display("FAIL err_misalign got e=%b d=%h lat=%0d we_at=%0d want e=01 d=0 lat=2 we_at=0",
               e, d, lat, we_at);
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h1003, 32'hFFFF_FFFF, lat, we_at, d, e);
    total++;
    if (e !== 2'b11 || d !== 32'h0 || lat !== 2 || we_at !== 0 || we_count !== w0) begin
      bad++;
      $display("FAIL err_both got e=%b d=%h lat=%0d we_at=%0d n=%0d want e=11 d=0 lat=2 we_at=0 n=%0d",
               e, d, lat, we_at, we_count, w0);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0, lat, we_at, d, e);
    total++;
    if (e !== 2'b00 || d !== 32'h0000_0011 || lat !== 2) begin
      bad++;
      $display("FAIL last_word got e=%b d=%h lat=%0d want e=00 d=00000011 lat=2", e, d, lat);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h1000, 32'h0, lat, we_at, d, e);
    total++;
    if (e !== 2'b10 || d !== 32'h0 || lat !== 2) begin
      bad++;
      $display("FAIL err_range got e=%b d=%h lat=%0d want e=10 d=0 lat=2", e, d, lat);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int w0;
    @(negedge clk);
    mem[1] = 32'h8899_AABB;
    w0 = we_count;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h4;
    bus.req_wdata    = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++;
    if (bus.req_ready !== 1'b0 || mem_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL rst_rmw_state got rdy=%b we=%b want rdy=0 we=0", bus.req_ready, mem_write_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (mem_write_enable !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_err !== 2'b00 || mem_address !== 32'h0 || mem_write_data !== 32'h0 ||
        bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_async got we=%b v=%b d=%h e=%b a=%h wd=%h rdy=%b want all 0, rdy=1",
               mem_write_enable, bus.resp_valid, bus.resp_rdata, bus.resp_err,
               mem_address, mem_write_data, bus.req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || mem[1] !== 32'h8899_AABB || we_count !== w0 || bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_after got rdy=%b m=%h n=%0d v=%b want rdy=1 m=8899aabb n=%0d v=0",
               bus.req_ready, mem[1], we_count, bus.resp_valid, w0);
    end
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    we_count         = 0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_back_to_back();
    test_errors();
    test_reset_mid_rmw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and data_memory.
- Accepts byte, halfword and word load/store requests on a valid/ready handshake. Converts byte addresses to word indices and sign- or zero-extends loads.
- Data memory only writes whole words, so sub-word stores run as a read-modify-write. Misaligned and out-of-range requests are reported and never touch memory.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached data memory; valid word index 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 reserved, treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte in [7:0], halfword in [15:0].
- resp_valid  out  1  one-cycle pulse, request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  bit0 misaligned, bit1 out of range; both may be set.
- mem_address  out  32  word index to data_memory, equal to latched req_addr[31:2].
- mem_write_data  out  32  word to write.
- mem_write_enable  out  1  write strobe.
- mem_read_data  in  32  combinational read data from data_memory.

Behaviour:
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_write_enable 0, mem_address 0, mem_write_data 0.
- Reset is asynchronous. Asserting it in any state forces IDLE and drops mem_write_enable immediately, so no write occurs at the next edge.
- req_ready = (state == IDLE). A handshake occurs on a posedge with req_valid && req_ready. On a handshake, latch we, size, unsigned, addr and wdata.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Out of range: addr[31:2] >= DEPTH.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, ERR.
  - IDLE, on handshake: go to ERR if either error is detected; else LOAD if load; else WRITE if word store; else RMW_RD.
  - LOAD: register the extracted lane, extended, into resp_rdata; go to IDLE with resp_valid=1 next cycle.
  - RMW_RD: capture mem_read_data into a merge register with the addressed lane replaced by wdata[7:0] or wdata[15:0]; go to WRITE.
  - WRITE: mem_write_enable=1, mem_write_data = merged word (or wdata for word stores); go to IDLE with resp_valid=1.
  - ERR: no memory access, mem_write_enable stays 0; go to IDLE with resp_valid=1, resp_err set, resp_rdata=0.
- Latency from handshake edge T0:
  - Load, word store and error: resp_valid high during cycle T2.
  - Sub-word store: resp_valid high during cycle T3.
- Back-to-back: resp_valid is asserted while already in IDLE, so a new request may be accepted in the same cycle resp_valid is high.
- resp_valid is a registered single-cycle pulse. resp_rdata and resp_err hold until the next completion.
- mem_write_enable is asserted only in WRITE, for exactly one cycle per store.
- Lanes are little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - halfword h = addr[1] occupies bits [16h+15:16h].
- Sign extension replicates the lane's MSB.

Decomposition:
- Shared package lsu_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - FSM state enum;
  - ERR_MISALIGN=0 and ERR_RANGE=1 bit positions.
- One combinational sub-module, lsu_lane_align, handles both load extraction/extension and store merge, given size, offset, unsigned flag, the old word and the new data.
- The FSM and registers live in load_store_unit.

Test Plan:
- Preload mem[1]=0x8899AABB; signed byte load addr 0x5 -> resp_rdata=0xFFFFFFAA, err=00, resp_valid at T2. Unsigned load of the same -> 0x000000AA.
- Halfword store wdata=0x00001234 to addr 0x6 with mem[1]=0x8899AABB -> one write strobe at T2, mem[1]=0x1234AABB, resp_valid at T3.
- Word store 0xDEADBEEF to addr 0x8 followed immediately by word load of addr 0x8, the second accepted in the resp_valid cycle -> load returns 0xDEADBEEF.
- Word load addr 0x2 -> err=01, rdata=0. Halfword store to addr 0x1003 with DEPTH=1024 -> err=11. In both cases mem_write_enable never asserts.
- Byte store 0x55 to addr 0x4; deassert rst_n during RMW_RD -> mem[1] unchanged, all outputs reset, req_ready=1 after release.
